button_step_ctrl: RTL

BUTTON_STEP_CTRL -- requirements
Module: button_step_ctrl

---
 rtl/button_step_ctrl_pkg.sv | 18 +
 rtl/button_step_ctrl_debounce_cell.sv | 85 ++++++++
 rtl/button_step_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/button_step_ctrl_pkg.sv
// Shared types and defaults for the button debounce / CPU step controller.
package button_step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE_LO,
    ARM_HI,
    IDLE_HI,
    ARM_LO
  } db_state_t;

  localparam int unsigned DEF_DB_CYCLES  = 1000000;
  localparam int unsigned DEF_AUTO_DIV_W = 27;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_step_ctrl_debounce_cell.sv
// One button: 2-flop synchronizer, 4-state debounce FSM, stability counter
// and rising-edge pulse.
module debounce_cell
  import button_step_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic iclk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          in;
  db_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          level_q;

  assign in = sync[1];

  always_ff @(posedge iclk) begin
    if (rst) begin
      sync    <= '0;
      state   <= IDLE_LO;
      cnt     <= '0;
      level_q <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      state   <= state_nx;
      cnt     <= cnt_nx;
      level_q <= level;
    end
  end

  // A bounce back to the settled level abandons the arm attempt.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE_LO: begin
        if (in) begin
          state_nx = ARM_HI;
          cnt_nx   = '0;
        end
      end
      ARM_HI: begin
        if (!in) begin
          state_nx = IDLE_LO;
        end else if (cnt == CNT_MAX) begin
          state_nx = IDLE_HI;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!in) begin
          state_nx = ARM_LO;
          cnt_nx   = '0;
        end
      end
      ARM_LO: begin
        if (in) begin
          state_nx = IDLE_HI;
        end else if (cnt == CNT_MAX) begin
          state_nx = IDLE_LO;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE_LO;
        cnt_nx   = '0;
      end
    endcase
  end

  assign level = (state == IDLE_HI) || (state == ARM_LO);
  assign pulse = level & ~level_q;

endmodule

// File: rtl/button_step_ctrl.sv
// Debounced buttons plus CPU single-step / auto-step enable generator.
// Auto-step divider and run_mode path exist only with STEP_AUTORUN_EN.
module button_step_ctrl
  import button_step_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned AUTO_DIV_W = DEF_AUTO_DIV_W
) (
  input  logic        iclk,
  input  logic        rst,
  input  logic [3:0]  button,
  input  logic        run_mode,
  output logic [3:0]  button_level,
  output logic [3:0]  button_pulse,
  output logic        step_pulse,
  output logic [31:0] step_count
);

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES)
    ) u_cell (
      .iclk (iclk),
      .rst  (rst),
      .raw  (button[i]),
      .level(button_level[i]),
      .pulse(button_pulse[i])
    );
  end

`ifdef STEP_AUTORUN_EN
  logic [1:0]            mode_sync;
  logic                  mode_q;
  logic                  mode_chg;
  logic [AUTO_DIV_W-1:0] div;

  assign mode_chg = mode_sync[1] ^ mode_q;

  always_ff @(posedge iclk) begin
    if (rst) begin
      mode_sync <= '0;
      mode_q    <= 1'b0;
      div       <= '0;
    end else begin
      mode_sync <= {mode_sync[0], run_mode};
      mode_q    <= mode_sync[1];
      div       <= mode_chg ? '0 : div + 1'b1;
    end
  end

  // A mode switch restarts the period and never emits a step itself.
  always_comb begin
    step_pulse = 1'b0;
    if (!mode_chg) begin
      step_pulse = mode_sync[1] ? (&div) : button_pulse[0];
    end
  end
`else
  logic [AUTO_DIV_W:0] unused_auto;

  assign unused_auto = {AUTO_DIV_W'(0), run_mode};
  assign step_pulse  = button_pulse[0];
`endif

  always_ff @(posedge iclk) begin
    if (rst) begin
      step_count <= '0;
    end else if (step_pulse) begin
      step_count <= step_count + 32'd1;
    end
  end

endmodule
